// File: rtl/button_event_arbiter_pkg.sv
// Shared constants for the button event arbiter: default button count,
// logical button indices and arbiter FSM state encodings.
package button_event_arbiter_pkg;

  localparam int N_BTN_DEFAULT = 4;

  localparam int BTN_UP      = 0;
  localparam int BTN_DOWN    = 1;
  localparam int BTN_RST_CNT = 2;
  localparam int BTN_MODE    = 3;

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_OFFER = 1'b1;

endpackage

// File: rtl/button_event_arbiter_if.sv
// Valid/ready event channel from the arbiter to the counter/control logic.
interface button_event_arbiter_if #(
  parameter int N_BTN = 4
);
  localparam int ID_W = $clog2(N_BTN);

  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);

endinterface

// File: rtl/button_event_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr,
// wrapping, found by rotating a doubled copy of the request vector.
module button_event_arbiter_rr_pick #(
  parameter int N_BTN = 4
) (
  input  logic [N_BTN-1:0]         req,
  input  logic [$clog2(N_BTN)-1:0] ptr,
  output logic                     any,
  output logic [$clog2(N_BTN)-1:0] idx
);
  localparam int ID_W = $clog2(N_BTN);

  logic [2*N_BTN-1:0] req2;
  logic [N_BTN-1:0]   rot;
  logic [ID_W:0]      off;
  logic [ID_W:0]      sum;

  assign req2 = {req, req} >> ptr;
  assign rot  = req2[N_BTN-1:0];
  assign any  = |req;

  // Lowest set bit of the rotated vector is the distance from ptr to the winner.
  always_comb begin
    off = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = (ID_W+1)'(k);
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (ID_W+1)'(N_BTN)) begin
      sum = sum - (ID_W+1)'(N_BTN);
    end
    idx = sum[ID_W-1:0];
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Queues one pending press per button, grants them round-robin over a
// valid/ready channel and counts presses lost to an already-pending button.
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter int N_BTN  = N_BTN_DEFAULT,
  parameter int DROP_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_BTN-1:0]      pressed,
  button_event_arbiter_if.master evt,
  output logic [DROP_W-1:0]     drop_cnt,
  input  logic                  drop_clr
);
  localparam int ID_W = $clog2(N_BTN);

  logic [N_BTN-1:0]  pending_q, pending_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [0:0]        state_q, state_d;
  logic              evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]   evt_id_q, evt_id_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic              pick_any;
  logic [ID_W-1:0]   pick_idx;
  logic              grant;
  logic [N_BTN-1:0]  grant_mask;
  logic [N_BTN-1:0]  drop_vec;
  logic [ID_W:0]     ptr_next;

  button_event_arbiter_rr_pick #(.N_BTN(N_BTN)) u_pick (
    .req (pending_q),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // A new winner is taken from idle, or on an accepted offer, so back-to-back
  // events never leave a bubble.
  always_comb begin
    grant = 1'b0;
    if (state_q == ARB_IDLE) begin
      grant = pick_any;
    end else if (evt_valid_q && evt.evt_ready) begin
      grant = pick_any;
    end

    grant_mask = '0;
    if (grant) begin
      grant_mask[pick_idx] = 1'b1;
    end

    ptr_next = {1'b0, pick_idx} + (ID_W+1)'(1);
    if (ptr_next == (ID_W+1)'(N_BTN)) begin
      ptr_next = '0;
    end
  end

  // A press only counts as dropped if its bit survives this edge still set.
  always_comb begin
    drop_vec  = pressed & pending_q & ~grant_mask;
    pending_d = (pending_q & ~grant_mask) | pressed;

    drop_cnt_d = drop_cnt_q;
    if (drop_clr) begin
      drop_cnt_d = '0;
    end else if ((|drop_vec) && !(&drop_cnt_q)) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    rr_ptr_d    = rr_ptr_q;

    if (grant) begin
      rr_ptr_d    = ptr_next[ID_W-1:0];
      evt_id_d    = pick_idx;
      evt_valid_d = 1'b1;
      state_d     = ARB_OFFER;
    end else if (state_q == ARB_OFFER && evt_valid_q && evt.evt_ready) begin
      evt_valid_d = 1'b0;
      state_d     = ARB_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      state_q     <= ARB_IDLE;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      drop_cnt_q  <= '0;
    end else begin
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      state_q     <= state_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_id    = evt_id_q;
  assign drop_cnt      = drop_cnt_q;

endmodule
